// File: rtl/linea_calle_scroll.sv
`default_nettype none
// ============================================================================
// Module   : linea_calle_scroll
// Brief    : Dashed lane-divider overlay for the road scene. The dash pattern
//            scrolls down by `speed` rows per frame. Optional macro
//            EDGE_LINES_EN adds solid road edge lines.
// Revision : 1.0 - initial release
// ============================================================================
module linea_calle_scroll #(
    parameter int          ROAD_X     = 200,
    parameter int          LANE_PITCH = 80,
    parameter int          NUM_LINES  = 2,
    parameter int          LINE_W     = 6,
    parameter int          DASH_LEN   = 40,
    parameter int          GAP_LEN    = 40,
    parameter int          ROAD_Y0    = 0,
    parameter int          ROAD_Y1    = 480,
    parameter int          V_ACTIVE   = 480,
    parameter logic [7:0]  LINE_COLOR = 8'hFF
`ifdef EDGE_LINES_EN
    ,
    parameter logic [7:0]  EDGE_COLOR = 8'hFC
`endif
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [3:0] speed,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       data
);

    localparam int c_period = DASH_LEN + GAP_LEN;
    localparam int c_pw     = (c_period > 2) ? $clog2(c_period) : 1;
    localparam int c_sw     = c_pw + 5;

    logic [c_pw-1:0]      r_ofs;
    logic [c_pw-1:0]      r_phase;
    logic                 r_data;
    logic [7:0]           r_rgb;

    logic                 w_tick;
    logic [c_sw-1:0]      w_spd;
    logic [c_sw-1:0]      w_sum;
    logic [c_sw-1:0]      w_ofs_next;
    logic [c_sw-1:0]      w_load;
    logic [c_pw-1:0]      w_phase_inc;
    logic                 w_y0;
    logic                 w_y1;
    logic                 w_dash;
    logic [NUM_LINES-1:0] w_line;
    logic                 w_div_hit;
    logic                 w_pix_data;
    logic [7:0]           w_pix_rgb;

    assign w_tick = (vcount == 10'(V_ACTIVE)) && (hcount == 10'd0);

    always_comb begin
        w_spd       = (c_sw'(speed) > c_sw'(c_period - 1)) ? c_sw'(c_period - 1) : c_sw'(speed);
        w_sum       = c_sw'(r_ofs) + w_spd;
        w_ofs_next  = (w_sum >= c_sw'(c_period)) ? (w_sum - c_sw'(c_period)) : w_sum;
        // First-row phase is (0 - ofs) mod PERIOD
        w_load      = (r_ofs == '0) ? '0 : (c_sw'(c_period) - c_sw'(r_ofs));
        w_phase_inc = (r_phase == c_pw'(c_period - 1)) ? '0 : (r_phase + c_pw'(1));
    end

    // Column windows use 11-bit compares so Lk+LINE_W cannot wrap past 1023
    for (genvar k = 0; k < NUM_LINES; k++) begin : g_line
        localparam int c_lo = ROAD_X + (k + 1) * LANE_PITCH;
        if (c_lo >= 1024) begin : g_off
            assign w_line[k] = 1'b0;
        end else begin : g_on
            assign w_line[k] = ({1'b0, hcount} >= 11'(c_lo)) &&
                               ({1'b0, hcount} <  11'(c_lo + LINE_W));
        end
    end

    if (ROAD_Y0 > 0) begin : g_y0
        assign w_y0 = ({1'b0, vcount} >= 11'(ROAD_Y0));
    end else begin : g_y0_open
        assign w_y0 = 1'b1;
    end

    assign w_y1      = ({1'b0, vcount} < 11'(ROAD_Y1));
    assign w_dash    = ({1'b0, r_phase} < (c_pw + 1)'(DASH_LEN));
    assign w_div_hit = enable && w_y0 && w_y1 && w_dash && (|w_line);

`ifdef EDGE_LINES_EN
    localparam int c_el = ROAD_X - LINE_W;
    localparam int c_er = ROAD_X + (NUM_LINES + 1) * LANE_PITCH;
    logic w_edge_hit;

    assign w_edge_hit = enable && w_y0 && w_y1 &&
                        ((({1'b0, hcount} >= 11'(c_el)) && ({1'b0, hcount} < 11'(ROAD_X))) ||
                         (({1'b0, hcount} >= 11'(c_er)) && ({1'b0, hcount} < 11'(c_er + LINE_W))));
`endif

    always_comb begin
        w_pix_data = 1'b0;
        w_pix_rgb  = 8'h00;
        if (w_div_hit) begin
            w_pix_data = 1'b1;
            w_pix_rgb  = LINE_COLOR;
        end
`ifdef EDGE_LINES_EN
        else if (w_edge_hit) begin
            w_pix_data = 1'b1;
            w_pix_rgb  = EDGE_COLOR;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_ofs   <= '0;
            r_phase <= '0;
            r_data  <= 1'b0;
            r_rgb   <= 8'h00;
        end else begin
            if (w_tick && enable) begin
                r_ofs <= c_pw'(w_ofs_next);
            end
            if (hcount == 10'd0) begin
                r_phase <= (vcount == 10'd0) ? c_pw'(w_load) : w_phase_inc;
            end
            r_data <= w_pix_data;
            r_rgb  <= w_pix_rgb;
        end
    end

    assign data              = r_data;
    assign {red, green, blue} = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_linea_calle_scroll.sv
`default_nettype none
// ============================================================================
// Module   : tb_linea_calle_scroll
// Brief    : Directed bench; drives a compressed scan (hcount=0 then one probe
//            column per row) and checks the registered pixel output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_linea_calle_scroll;

    logic       clock = 1'b0;
    logic       reset_n, reset_n2, enable;
    logic [3:0] speed;
    logic [9:0] hcount, vcount;
    logic [2:0] red, green, red2, green2;
    logic [1:0] blue, blue2;
    logic       data, data2;
    logic [8:0] w_pix1, w_pix2;

    int total = 0;
    int bad   = 0;
    int cur_v = 0;

    localparam logic [8:0] c_dash = 9'h1FF;
    localparam logic [8:0] c_none = 9'h000;

    always #5 clock = ~clock;

    linea_calle_scroll u_dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .speed(speed),
        .hcount(hcount), .vcount(vcount),
        .red(red), .green(green), .blue(blue), .data(data)
    );

    // PERIOD = 12 instance for the speed clamp
    linea_calle_scroll #(.DASH_LEN(6), .GAP_LEN(6)) u_dut12 (
        .clock(clock), .reset_n(reset_n2), .enable(enable), .speed(speed),
        .hcount(hcount), .vcount(vcount),
        .red(red2), .green(green2), .blue(blue2), .data(data2)
    );

    assign w_pix1 = {data, red, green, blue};
    assign w_pix2 = {data2, red2, green2, blue2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called and returns at a negedge; output sampled reflects (v, h)
    task automatic row(input int v, input int h);
        vcount = 10'(v);
        hcount = 10'd0;
        @(negedge clock);
        hcount = 10'(h);
        @(negedge clock);
    endtask

    task automatic goto_row(input int v, input int h);
        while (cur_v <= v) begin
            row(cur_v, h);
            cur_v++;
        end
    endtask

    task automatic tick();
        vcount = 10'd480;
        hcount = 10'd0;
        @(negedge clock);
        hcount = 10'd1;
        cur_v  = 0;
    endtask

    initial begin
        reset_n  = 1'b0;
        reset_n2 = 1'b0;
        enable   = 1'b1;
        speed    = 4'd0;
        hcount   = 10'd282;
        vcount   = 10'd10;
        repeat (3) @(negedge clock);
        check("reset_pix", 32'(w_pix1), 32'(c_none));
        check("reset_pix12", 32'(w_pix2), 32'(c_none));
        reset_n = 1'b1;

        // ofs = 0: dash rows 0..39, line0 at [280,286), line1 at [360,366)
        goto_row(5, 279);   check("col_279", 32'(w_pix1), 32'(c_none));
        goto_row(6, 286);   check("col_286", 32'(w_pix1), 32'(c_none));
        goto_row(7, 285);   check("col_285", 32'(w_pix1), 32'(c_dash));
        goto_row(10, 282);  check("v10_h282", 32'(w_pix1), 32'(c_dash));
        goto_row(39, 282);  check("v39_last_dash", 32'(w_pix1), 32'(c_dash));
        goto_row(40, 282);  check("v40_gap", 32'(w_pix1), 32'(c_none));
        goto_row(50, 282);  check("v50_gap", 32'(w_pix1), 32'(c_none));

        // speed 5, two ticks -> ofs 10: dash rows 10..49
        speed = 4'd5;
        tick();
        tick();
        goto_row(5, 362);   check("ofs10_v5", 32'(w_pix1), 32'(c_none));
        goto_row(10, 362);  check("ofs10_v10", 32'(w_pix1), 32'(c_dash));
        goto_row(49, 362);  check("ofs10_v49", 32'(w_pix1), 32'(c_dash));
        goto_row(50, 362);  check("ofs10_v50", 32'(w_pix1), 32'(c_none));

        // speed 15 on PERIOD 12 clamps to 11 -> ofs 11: rows 11..16 and 0..4 dashed
        reset_n2 = 1'b1;
        speed    = 4'd15;
        tick();             // main ofs 10+15 = 25
        goto_row(4, 282);   check("p12_v4", 32'(w_pix2), 32'(c_dash));
        goto_row(5, 282);   check("p12_v5", 32'(w_pix2), 32'(c_none));
        goto_row(10, 282);  check("p12_v10", 32'(w_pix2), 32'(c_none));
        goto_row(11, 282);  check("p12_v11", 32'(w_pix2), 32'(c_dash));

        // five more ticks at 15: 25+75 = 100 mod 80 = 20, dash rows 20..59
        repeat (5) tick();
        goto_row(19, 282);  check("wrap_v19", 32'(w_pix1), 32'(c_none));
        goto_row(20, 282);  check("wrap_v20", 32'(w_pix1), 32'(c_dash));
        goto_row(59, 282);  check("wrap_v59", 32'(w_pix1), 32'(c_dash));
        goto_row(60, 282);  check("wrap_v60", 32'(w_pix1), 32'(c_none));

        // pause across a tick: ofs stays 20
        enable = 1'b0;
        tick();
        goto_row(25, 282);  check("pause_v25", 32'(w_pix1), 32'(c_none));
        enable = 1'b1;
        goto_row(26, 282);  check("resume_v26", 32'(w_pix1), 32'(c_dash));
        goto_row(30, 282);  check("resume_v30", 32'(w_pix1), 32'(c_dash));
        enable = 1'b0;
        @(negedge clock);
        check("enable_fall", 32'(w_pix1), 32'(c_none));
        enable = 1'b1;

        // ofs 30: row 200 phase 10 -> dash; reset pulse clears the pixel
        speed = 4'd10;
        tick();
        goto_row(200, 282); check("ofs30_v200", 32'(w_pix1), 32'(c_dash));
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        check("midframe_reset", 32'(w_pix1), 32'(c_none));

        // next frame from ofs 0: dash rows 0..39
        speed = 4'd0;
        tick();
        goto_row(0, 282);   check("post_rst_v0", 32'(w_pix1), 32'(c_dash));
        goto_row(39, 282);  check("post_rst_v39", 32'(w_pix1), 32'(c_dash));
        goto_row(40, 282);  check("post_rst_v40", 32'(w_pix1), 32'(c_none));

        goto_row(300, 196);
`ifdef EDGE_LINES_EN
        check("edge_left", 32'(w_pix1), 32'(9'h1FC));
`else
        check("edge_left", 32'(w_pix1), 32'(c_none));
`endif
        // row 481 has phase 1 (dash) but lies below the road window
        goto_row(481, 282); check("below_road", 32'(w_pix1), 32'(c_none));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
